uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter attached to the SoC data bus, alongside the data memory.
- It takes processor store/load traffic (ce, we, addr, wtData), buffers bytes in a small FIFO, and serialises them 8N1 on txd.
- Read data returns on rdData so the top level can mux it against data-memory read data by address.

---
 rtl/uart_tx_mmio.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus writes feed a small byte FIFO that a
// baud-timed FSM drains onto txd. Register block is TXDATA / STATUS / BAUDDIV.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
    parameter logic [15:0] DIV_DEFAULT = 16'd434,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        hit,
    output logic        txd,
    output logic        txIdle
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Bus: one access per cycle while ce is high; writes commit at the rising
    // edge, reads are combinational in the same cycle and have no side effects.
    logic [31:0] offset;
    logic [1:0]  reg_sel;
    logic        wr_tx;
    logic        wr_stat;
    logic        wr_div;

    assign offset  = addr - BASE_ADDR;
    assign hit     = ce & (offset < 32'd12);
    assign reg_sel = offset[3:2];
    assign wr_tx   = hit & we & (reg_sel == 2'd0);
    assign wr_stat = hit & we & (reg_sel == 2'd1);
    assign wr_div  = hit & we & (reg_sel == 2'd2);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic [15:0]   baud_div;

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic [15:0]   reload;

    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          busy;

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign busy   = (state != IDLE);
    assign txIdle = empty & (state == IDLE);
    assign reload = baud_div - 16'd1;

    // The FSM takes a byte either from IDLE or at the very end of a stop bit,
    // which is what lets a push into a full FIFO still be accepted.
    assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & (baud_cnt == 16'd0)));
    assign push_ok = wr_tx & (~full | pop);
    assign drop    = wr_tx & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wtData[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            baud_div <= DIV_DEFAULT;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (wr_stat & wtData[3]) begin
                ovf <= 1'b0;
            end
            if (wr_div) begin
                baud_div <= (wtData[15:0] == 16'd0) ? 16'd1 : wtData[15:0];
            end
        end
    end

    // baud_cnt is reloaded from BAUDDIV only at bit boundaries, so a divider
    // write mid-bit does not stretch or shorten the bit in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= 8'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= 16'd0;
            txd      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        baud_cnt <= reload;
                        txd      <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= reload;
                        bit_idx  <= 3'd0;
                        txd      <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= reload;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == 16'd0) begin
                        if (pop) begin
                            shreg    <= mem[rd_ptr];
                            baud_cnt <= reload;
                            txd      <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rdData = 32'd0;
        if (hit & ~we) begin
            case (reg_sel)
                2'd1:    rdData = {23'd0, 5'(count), ovf, busy, empty, full};
                2'd2:    rdData = {16'd0, baud_div};
                default: rdData = 32'd0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wtData[31:16], offset[1:0]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: bus driver tasks, a txd frame decoder feeding a
// byte scoreboard, and directed register/timing checks.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE     = 32'h0000_8000;
    localparam logic [31:0] ADDR_TX  = BASE;
    localparam logic [31:0] ADDR_ST  = BASE + 32'h4;
    localparam logic [31:0] ADDR_DIV = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wtData = 32'd0;
    logic [31:0] rdData;
    logic        hit;
    logic        txd;
    logic        txIdle;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .DIV_DEFAULT(16'd434),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .we    (we),
        .addr  (addr),
        .wtData(wtData),
        .rdData(rdData),
        .hit   (hit),
        .txd   (txd),
        .txIdle(txIdle)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // checking
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // scoreboard
    logic [7:0] exp_q[$];
    int         cur_div = 434;

    bit         in_frame = 1'b0;
    int         pos = 0;
    int         k = 0;
    int         n_frames = 0;
    int         last_start = 0;
    int         prev_start = 0;
    logic [7:0] rx = 8'd0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (txd === 1'b0) begin
                    in_frame   = 1'b1;
                    pos        = 0;
                    rx         = 8'd0;
                    prev_start = last_start;
                    last_start = cyc;
                    n_frames++;
                end
            end else begin
                pos++;
            end
            if (in_frame && (pos % cur_div == cur_div / 2)) begin
                k = pos / cur_div;
                if (k == 0) begin
                    check_eq("start_bit", 32'(txd), 32'd0);
                end else if (k <= 8) begin
                    rx[k-1] = txd;
                end else begin
                    check_eq("stop_bit", 32'(txd), 32'd1);
                    check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check_eq("rx_byte", 32'(rx), 32'(exp_b));
                    end
                    in_frame = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        ce     = 1'b1;
        we     = 1'b1;
        addr   = a;
        wtData = d;
        @(posedge clk);
        #1;
        ce = 1'b0;
        we = 1'b0;
        if (a == ADDR_DIV) cur_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        do_write(a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        @(negedge clk);
        ce   = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        d  = rdData;
        h  = hit;
        ce = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int  i;
        bit  ok;
        i = 0;
        while (!(txIdle && exp_q.size() == 0 && !in_frame) && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        ok = txIdle && (exp_q.size() == 0) && !in_frame;
        check_eq("drain_done", 32'(ok), 32'd1);
    endtask

    // stimulus
    logic [31:0] d;
    logic        h;
    int          t0;
    int          lows;
    int          frames_before;
    logic [7:0]  b [10];

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_txd", 32'(txd), 32'd1);
        check_eq("rst_txidle", 32'(txIdle), 32'd1);
        rst = 1'b1;
        bus_read(ADDR_ST, d, h);
        check_eq("rst_status", d, 32'h0000_0002);
        check_eq("hit_status", 32'(h), 32'd1);
        bus_read(ADDR_DIV, d, h);
        check_eq("rst_bauddiv", d, 32'd434);
        bus_read(ADDR_TX, d, h);
        check_eq("txdata_reads0", d, 32'd0);
        bus_read(BASE + 32'h6, d, h);
        check_eq("status_low_bits_ignored", d, 32'h0000_0002);
        bus_read(BASE + 32'hB, d, h);
        check_eq("hit_top_byte", 32'(h), 32'd1);
        check_eq("div_top_byte", d, 32'd434);
        bus_read(BASE + 32'hC, d, h);
        check_eq("hit_off_c", 32'(h), 32'd0);
        check_eq("rd_off_c", d, 32'd0);
        bus_read(BASE - 32'h4, d, h);
        check_eq("hit_below", 32'(h), 32'd0);
        @(negedge clk);
        addr = BASE;
        ce   = 1'b0;
        #1;
        check_eq("hit_no_ce", 32'(hit), 32'd0);

        bus_write(BASE + 32'hC, 32'd5);
        bus_write(32'h0000_0000, 32'h77);
        bus_read(ADDR_DIV, d, h);
        check_eq("div_after_ignored_wr", d, 32'd434);
        bus_write(ADDR_DIV, 32'd0);
        bus_read(ADDR_DIV, d, h);
        check_eq("div_zero_is_one", d, 32'd1);
        bus_read(ADDR_ST, d, h);
        check_eq("status_no_stray_push", d, 32'h0000_0002);

        // single frame, latency and frame length
        bus_write(ADDR_DIV, 32'd4);
        exp_q.push_back(8'h55);
        bus_write(ADDR_TX, 32'h55);
        t0 = cyc;
        check_eq("lat_push_edge", 32'(txd), 32'd1);
        wait_until(t0 + 1);
        check_eq("lat_start", 32'(txd), 32'd0);
        wait_until(t0 + 40);
        check_eq("txidle_in_stop", 32'(txIdle), 32'd0);
        wait_until(t0 + 41);
        check_eq("txidle_after_frame", 32'(txIdle), 32'd1);
        check_eq("frame_55_received", 32'(exp_q.size()), 32'd0);

        // back-to-back frames
        bus_write(ADDR_DIV, 32'd2);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        bus_write(ADDR_TX, 32'hA5);
        t0 = cyc;
        bus_write(ADDR_TX, 32'h3C);
        bus_read(ADDR_ST, d, h);
        check_eq("b2b_status_1", d, 32'h0000_0014);
        wait_until(t0 + 21);
        bus_read(ADDR_ST, d, h);
        check_eq("b2b_status_0", d, 32'h0000_0006);
        wait_drain(200);
        bus_read(ADDR_ST, d, h);
        check_eq("b2b_status_idle", d, 32'h0000_0002);
        check_eq("b2b_second_start", 32'(last_start), 32'(t0 + 21));
        check_eq("b2b_gap", 32'(last_start - prev_start), 32'd20);

        // overflow, OVF clear, push on STOP-end pop with a full FIFO
        bus_write(ADDR_DIV, 32'd100);
        for (int i = 0; i < 10; i++) begin
            b[i] = 8'($urandom_range(0, 255));
            if (i < 9) exp_q.push_back(b[i]);
            bus_write(ADDR_TX, 32'(b[i]));
            if (i == 0) t0 = cyc;
        end
        bus_read(ADDR_ST, d, h);
        check_eq("ovf_status", d, 32'h0000_008D);
        bus_write(ADDR_ST, 32'h8);
        bus_read(ADDR_ST, d, h);
        check_eq("ovf_cleared", d, 32'h0000_0085);
        check_eq("before_stop_end", 32'(cyc < t0 + 1000), 32'd1);
        while (cyc < t0 + 1000) begin
            @(posedge clk);
            #1;
        end
        exp_q.push_back(8'hEE);
        do_write(ADDR_TX, 32'hEE);
        bus_read(ADDR_ST, d, h);
        check_eq("full_push_with_pop", d, 32'h0000_0085);
        wait_drain(12000);
        bus_read(ADDR_ST, d, h);
        check_eq("ovf_drained_status", d, 32'h0000_0002);

        // reset in the middle of data bit 3
        bus_write(ADDR_DIV, 32'd4);
        exp_q.push_back(8'hC3);
        bus_write(ADDR_TX, 32'hC3);
        t0 = cyc;
        wait_until(t0 + 18);
        check_eq("data_bit3_level", 32'(txd), 32'd0);
        exp_q.delete();
        frames_before = n_frames;
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_txd", 32'(txd), 32'd1);
        check_eq("async_rst_txidle", 32'(txIdle), 32'd1);
        ce   = 1'b1;
        we   = 1'b0;
        addr = ADDR_ST;
        #1;
        check_eq("async_rst_status", rdData, 32'h0000_0002);
        ce = 1'b0;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check_eq("no_residual_frame", 32'(lows), 32'd0);
        check_eq("no_new_frames", 32'(n_frames - frames_before), 32'd0);
        bus_read(ADDR_DIV, d, h);
        check_eq("div_after_rst", d, 32'd434);
        check_eq("txidle_after_rst", 32'(txIdle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
